// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state encodings, control levels and bus widths for the divider
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on the {partial remainder, dividend/quotient} work register
module div_step
  import div_unit_pkg::*;
#(
  parameter int W = RegBus
) (
  input  logic [2*W:0] i_work,
  input  logic [W-1:0] i_dvs,
  output logic [2*W:0] o_work
);

  logic [W:0] w_trial;

  assign w_trial = i_work[2*W:W] - {1'b0, i_dvs};

  // negative trial keeps the remainder and shifts in a 0 quotient bit; otherwise commit the subtraction and shift in a 1
  always_comb o_work = w_trial[W] ? {i_work[2*W-1:0], 1'b0} : {w_trial[W-1:0], i_work[W-1:0], 1'b1};

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle signed/unsigned restoring divider beside execute; result = {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: when |dividend| < |divisor| skip the iterations and finish one edge after entering ON.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = RegBus
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_in,
  input  logic [DATA_W-1:0]     opdata1_in,
  input  logic [DATA_W-1:0]     opdata2_in,
  input  logic                  start_in,
  input  logic                  annul_in,
  output logic [2*DATA_W-1:0]   result_out,
  output logic                  ready_out
);

  localparam int ResW  = (DATA_W == RegBus) ? DoubleRegBus : 2 * DATA_W;
  localparam int CntW  = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntDone = CntW'(DATA_W);

  div_state_e        r_state;
  logic [CntW-1:0]   r_cnt;
  logic [2*DATA_W:0] r_work;
  logic [DATA_W-1:0] r_dvs;
  logic              r_sign1;
  logic              r_sign2;
  logic              r_signed;
  logic [ResW-1:0]   r_result;
  logic              r_ready;

  logic [DATA_W-1:0] w_abs1;
  logic [DATA_W-1:0] w_abs2;
  logic [2*DATA_W:0] w_step;
  logic [DATA_W-1:0] w_quot;
  logic [DATA_W-1:0] w_rem;
  logic [DATA_W-1:0] w_quot_fix;
  logic [DATA_W-1:0] w_rem_fix;

  assign w_abs1     = (signed_div_in && opdata1_in[DATA_W-1]) ? -opdata1_in : opdata1_in;
  assign w_abs2     = (signed_div_in && opdata2_in[DATA_W-1]) ? -opdata2_in : opdata2_in;
  assign w_quot     = r_work[DATA_W-1:0];
  assign w_rem      = r_work[2*DATA_W:DATA_W+1];
  assign w_quot_fix = (r_signed && (r_sign1 ^ r_sign2)) ? -w_quot : w_quot;
  assign w_rem_fix  = (r_signed && r_sign1) ? -w_rem : w_rem;
  assign result_out = r_result;
  assign ready_out  = r_ready;

`ifdef DIV_EARLY_OUT_EN
  logic              w_early;
  logic [DATA_W-1:0] w_dd_fix;
  // on the first ON cycle the untouched dividend magnitude sits in work[DATA_W:1]
  assign w_early  = (r_cnt == '0) && (r_work[DATA_W:1] < r_dvs);
  assign w_dd_fix = (r_signed && r_sign1) ? -r_work[DATA_W:1] : r_work[DATA_W:1];
`endif

  div_step #(.W(DATA_W)) u_step (
    .i_work (r_work),
    .i_dvs  (r_dvs),
    .o_work (w_step)
  );

  // divider control FSM with registered result and ready; annul overrides every transition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= DivFree;
      r_cnt    <= '0;
      r_work   <= '0;
      r_dvs    <= '0;
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_signed <= 1'b0;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
    end else if (annul_in) begin
      r_state  <= DivFree;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          r_result <= '0;
          r_ready  <= DivResultNotReady;
          if (start_in == DivStart) begin
            if (opdata2_in == '0) begin
              r_state <= DivByZero;
            end else begin
              r_state  <= DivOn;
              r_cnt    <= '0;
              r_sign1  <= opdata1_in[DATA_W-1];
              r_sign2  <= opdata2_in[DATA_W-1];
              r_signed <= signed_div_in;
              r_dvs    <= w_abs2;
              // dividend sits one bit up so its MSB enters the trial window on the first step
              r_work   <= {{DATA_W{1'b0}}, w_abs1, 1'b0};
            end
          end
        end
        DivByZero: begin
          if (start_in == DivStop) begin
            r_state <= DivFree;
          end else begin
            r_state  <= DivEnd;
            r_result <= '0;
            r_ready  <= DivResultReady;
          end
        end
        DivOn: begin
          if (start_in == DivStop) begin
            r_state <= DivFree;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (w_early) begin
            r_state  <= DivEnd;
            r_result <= {w_dd_fix, {DATA_W{1'b0}}};
            r_ready  <= DivResultReady;
          end
`endif
          else if (r_cnt == CntDone) begin
            r_state  <= DivEnd;
            r_result <= {w_rem_fix, w_quot_fix};
            r_ready  <= DivResultReady;
          end else begin
            r_work <= w_step;
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        DivEnd: begin
          if (start_in == DivStop) begin
            r_state  <= DivFree;
            r_result <= '0;
            r_ready  <= DivResultNotReady;
          end
        end
        default: r_state <= DivFree;
      endcase
    end
  end

endmodule
